// File: rtl/shift_sequencer_if.sv
// Command/result channel bundle between the ALU decode stage and shift_sequencer.
//   master : the issuing side -- drives start_valid, op_*, res_ready
//   slave  : the sequencer    -- drives start_ready, res_valid, res_data, res_cout
// Command channel: start_valid/start_ready plus op_data, op_cin, op_mode, op_count.
// Result channel : res_valid/res_ready plus res_data, res_cout.
interface shift_sequencer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 4
);
  logic              start_valid;
  logic              start_ready;
  logic [DATA_W-1:0] op_data;
  logic              op_cin;
  logic [2:0]        op_mode;
  logic [CNT_W-1:0]  op_count;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_cout;

  modport master (
    output start_valid, op_data, op_cin, op_mode, op_count, res_ready,
    input  start_ready, res_valid, res_data, res_cout
  );

  modport slave (
    input  start_valid, op_data, op_cin, op_mode, op_count, res_ready,
    output start_ready, res_valid, res_data, res_cout
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-step controller for an external combinational 1-bit shift unit.
// Accepts a command (operand, carry-in, mode, step count), applies one 1-bit step per
// clock through the shift unit while feeding carry-out back as carry-in, then presents
// the final data/carry on a valid/ready result channel.
// Ports:
//   clk, rst_n      : clock (rising edge), synchronous active-low reset
//   cmd (slave)     : command and result channels, see shift_sequencer_if
//   busy            : high while shifting or holding a result
//   sh_in/cin/mode  : drive the shift unit inputs (straight from the working registers)
//   sh_out/cout     : shift unit results for the current step
module shift_sequencer #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned MAX_COUNT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  shift_sequencer_if.slave  cmd,
  output logic              busy,
  output logic [DATA_W-1:0] sh_in,
  output logic              sh_cin,
  output logic [2:0]        sh_mode,
  input  logic [DATA_W-1:0] sh_out,
  input  logic              sh_cout
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_COUNT);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              carry_q, carry_d;
  logic [2:0]        mode_q, mode_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_load;

  // Saturate once at load; the down-counter itself never sees an out-of-range value.
  assign cnt_load = (cmd.op_count > MaxCnt) ? MaxCnt : cmd.op_count;

  assign sh_in        = data_q;
  assign sh_cin       = carry_q;
  assign sh_mode      = mode_q;
  assign cmd.res_data = data_q;
  assign cmd.res_cout = carry_q;

  always_comb begin
    state_d         = state_q;
    data_d          = data_q;
    carry_d         = carry_q;
    mode_d          = mode_q;
    cnt_d           = cnt_q;
    cmd.start_ready = 1'b0;
    cmd.res_valid   = 1'b0;
    busy            = 1'b0;

    unique case (state_q)
      StIdle: begin
        cmd.start_ready = 1'b1;
        if (cmd.start_valid) begin
          data_d  = cmd.op_data;
          carry_d = cmd.op_cin;
          mode_d  = cmd.op_mode;
          cnt_d   = cnt_load;
          state_d = (cnt_load != '0) ? StShift : StDone;
        end
      end
      StShift: begin
        busy    = 1'b1;
        data_d  = sh_out;
        carry_d = sh_cout;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        busy          = 1'b1;
        cmd.res_valid = 1'b1;
        // start_ready stays low here, so a new command waits for IDLE.
        if (cmd.res_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      data_q  <= '0;
      carry_q <= 1'b0;
      mode_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      carry_q <= carry_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
